// File: rtl/divider_ctrl_if.sv
// Control/status bundle between the register bank and divider_ctrl.
// The master side (register bank / control FSM) drives the requests and the
// configuration. The slave side (divider_ctrl) returns status and the timebase.
// Optional burst mode is compiled in when DIVCTRL_BURST_EN is defined.
interface divider_ctrl_if #(
  parameter int CNT_W   = 25,
  parameter int BURST_W = 8
);

  logic             start;
  logic             stop;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             busy;
  logic [1:0]       state;
  logic             tick;
  logic             clk_out;
`ifdef DIVCTRL_BURST_EN
  logic [BURST_W-1:0] burst_len;
  logic               done;
`endif

`ifdef DIVCTRL_BURST_EN
  modport master (
    output start, stop, cfg_valid, cfg_div, burst_len,
    input  cfg_ready, busy, state, tick, clk_out, done
  );

  modport slave (
    input  start, stop, cfg_valid, cfg_div, burst_len,
    output cfg_ready, busy, state, tick, clk_out, done
  );
`else
  modport master (
    output start, stop, cfg_valid, cfg_div,
    input  cfg_ready, busy, state, tick, clk_out
  );

  modport slave (
    input  start, stop, cfg_valid, cfg_div,
    output cfg_ready, busy, state, tick, clk_out
  );
`endif

endinterface

// File: rtl/divider_ctrl.sv
// Run-time controller for the programmable clock-divider timebase.
// Owns the divide counter and sequences start, graceful stop and glitch-free
// divide-ratio reload. It emits a 1-cycle tick at every terminal count and a
// 50%-duty clk_out that toggles on each tick and is low whenever idle.
// A ratio offered while running is parked in pending_div_q and only takes effect
// at a terminal count. This way clk_out never produces a runt phase.
// Optional feature: define DIVCTRL_BURST_EN to add burst_len/done. A run then
// stops by itself after burst_len ticks. A burst_len of 0 keeps free-running.
module divider_ctrl #(
  parameter int CNT_W       = 25,
  parameter int DEFAULT_DIV = 24000000,
  parameter int BURST_W     = 8
) (
  input logic           clk_in,
  input logic           reset,
  divider_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RUN      = 2'b01,
    STOPPING = 2'b10
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] counter_q;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] pending_div_q;
  logic             pending_q;
  logic             clk_out_q;
  logic             tick_q;

  logic             terminal;
  logic             cfg_ready;
  logic             cfg_fire;
  logic [CNT_W-1:0] cfg_div_clamped;
  logic [CNT_W-1:0] div_d;

`ifdef DIVCTRL_BURST_EN
  logic [BURST_W-1:0] burst_len_q;
  logic [BURST_W-1:0] tick_cnt_q;
  logic               burst_fin_q;
  logic               done_q;
  logic               burst_last;
`endif

  // div_q is never zero, so div_q - 1 is always a valid terminal count.
  assign terminal        = (counter_q == (div_q - CNT_W'(1)));
  assign cfg_ready       = (state_q == IDLE) || ((state_q == RUN) && !pending_q);
  assign cfg_fire        = bus.cfg_valid && cfg_ready;
  assign cfg_div_clamped = (bus.cfg_div == '0) ? CNT_W'(1) : bus.cfg_div;
  assign div_d           = pending_q ? pending_div_q : div_q;

`ifdef DIVCTRL_BURST_EN
  assign burst_last = (burst_len_q != '0) && ((tick_cnt_q + BURST_W'(1)) == burst_len_q);
  assign bus.done   = done_q;
`endif

  assign bus.cfg_ready = cfg_ready;
  assign bus.busy      = (state_q != IDLE);
  assign bus.state     = state_q;
  assign bus.tick      = tick_q;
  assign bus.clk_out   = clk_out_q;

  // Control FSM with divide counter, reload sequencing and registered outputs.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      counter_q     <= '0;
      div_q         <= CNT_W'(DEFAULT_DIV);
      pending_div_q <= '0;
      pending_q     <= 1'b0;
      clk_out_q     <= 1'b0;
      tick_q        <= 1'b0;
`ifdef DIVCTRL_BURST_EN
      burst_len_q   <= '0;
      tick_cnt_q    <= '0;
      burst_fin_q   <= 1'b0;
      done_q        <= 1'b0;
`endif
    end else begin
      tick_q <= 1'b0;
`ifdef DIVCTRL_BURST_EN
      done_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          counter_q <= '0;
          clk_out_q <= 1'b0;
          if (cfg_fire) begin
            div_q <= cfg_div_clamped;
          end
          if (bus.start && !bus.stop) begin
            state_q     <= RUN;
`ifdef DIVCTRL_BURST_EN
            burst_len_q <= bus.burst_len;
            tick_cnt_q  <= '0;
            burst_fin_q <= 1'b0;
`endif
          end
        end

        RUN: begin
          if (cfg_fire) begin
            pending_div_q <= cfg_div_clamped;
            pending_q     <= 1'b1;
          end
          if (bus.stop) begin
            state_q <= STOPPING;
          end
          if (terminal) begin
            tick_q    <= 1'b1;
            counter_q <= '0;
            clk_out_q <= ~clk_out_q;
            div_q     <= div_d;
            if (pending_q) begin
              pending_q <= 1'b0;
            end
`ifdef DIVCTRL_BURST_EN
            tick_cnt_q <= tick_cnt_q + BURST_W'(1);
            // The last burst tick parks clk_out low, so STOPPING retires
            // without adding a tick beyond the requested count.
            if (burst_last) begin
              clk_out_q   <= 1'b0;
              state_q     <= STOPPING;
              burst_fin_q <= 1'b1;
            end
`endif
          end else begin
            counter_q <= counter_q + CNT_W'(1);
          end
        end

        STOPPING: begin
          if (!clk_out_q || terminal) begin
            state_q   <= IDLE;
            counter_q <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= clk_out_q;
            div_q     <= div_d;
            pending_q <= 1'b0;
`ifdef DIVCTRL_BURST_EN
            done_q      <= burst_fin_q;
            burst_fin_q <= 1'b0;
`endif
          end else begin
            counter_q <= counter_q + CNT_W'(1);
          end
        end

        default: begin
          state_q   <= IDLE;
          counter_q <= '0;
          clk_out_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_ctrl.sv
// Directed testbench for divider_ctrl. It uses a small divide ratio
// (DEFAULT_DIV = 4) so that every period can be checked cycle by cycle.
// The burst checks are compiled in when DIVCTRL_BURST_EN is defined.
module tb_divider_ctrl;

  localparam int CntW       = 8;
  localparam int DefaultDiv = 4;
  localparam int BurstW     = 8;

  logic clk = 1'b0;
  logic reset;
  int   testsRun    = 0;
  int   testsFailed = 0;

  divider_ctrl_if #(.CNT_W(CntW), .BURST_W(BurstW)) bus ();

  divider_ctrl #(
    .CNT_W      (CntW),
    .DEFAULT_DIV(DefaultDiv),
    .BURST_W    (BurstW)
  ) dut (
    .clk_in(clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10-time-unit system clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic v, input logic [CntW-1:0] d);
    bus.start     = s;
    bus.stop      = p;
    bus.cfg_valid = v;
    bus.cfg_div   = d;
  endtask

  // Inputs change on the falling edge and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic expTick [4];
    logic expClk  [4];
`ifdef DIVCTRL_BURST_EN
    int tickCount;
`endif

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
`ifdef DIVCTRL_BURST_EN
    bus.burst_len = '0;
`endif

    // Reset values.
    step();
    checkOutput("rst state", bus.state, 0);
    checkOutput("rst tick", bus.tick, 0);
    checkOutput("rst clk_out", bus.clk_out, 0);
    checkOutput("rst cfg_ready", bus.cfg_ready, 1);
    checkOutput("rst busy", bus.busy, 0);
    reset = 1'b0;

    // Default ratio 4: tick every 4 clocks and clk_out period 8.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    step();
    checkOutput("t1 state run", bus.state, 1);
    checkOutput("t1 busy", bus.busy, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    for (int n = 1; n <= 16; n++) begin
      step();
      checkOutput($sformatf("t1 tick n=%0d", n), bus.tick, (n % 4) == 0);
      checkOutput($sformatf("t1 clk_out n=%0d", n), bus.clk_out, (n / 4) % 2);
    end

    // Stop while clk_out is low: STOPPING, then IDLE with no tick.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    step();
    checkOutput("t3b state stopping", bus.state, 2);
    checkOutput("t3b tick0", bus.tick, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    step();
    checkOutput("t3b state idle", bus.state, 0);
    checkOutput("t3b tick1", bus.tick, 0);
    checkOutput("t3b clk_out", bus.clk_out, 0);

    // Mid-period reload 4 -> 2: the current period ends at 4, then ratio 2.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    step();
    step();
    checkOutput("t2 ready before", bus.cfg_ready, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd2);
    step();
    checkOutput("t2 ready pending", bus.cfg_ready, 0);
    checkOutput("t2 tick e3", bus.tick, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    step();
    checkOutput("t2 tick e4", bus.tick, 1);
    checkOutput("t2 ready reload", bus.cfg_ready, 1);
    checkOutput("t2 clk_out e4", bus.clk_out, 1);
    expTick = '{1'b0, 1'b1, 1'b0, 1'b1};
    expClk  = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int n = 0; n < 4; n++) begin
      step();
      checkOutput($sformatf("t2 tick e%0d", n + 5), bus.tick, expTick[n]);
      checkOutput($sformatf("t2 clk_out e%0d", n + 5), bus.clk_out, expClk[n]);
    end

    // Stop while clk_out is high: one final tick, then clk_out low and IDLE.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    step();
    checkOutput("t3a state stopping", bus.state, 2);
    checkOutput("t3a tick0", bus.tick, 0);
    checkOutput("t3a clk_out high", bus.clk_out, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    step();
    checkOutput("t3a state idle", bus.state, 0);
    checkOutput("t3a final tick", bus.tick, 1);
    checkOutput("t3a clk_out low", bus.clk_out, 0);
    step();
    checkOutput("t3a no more tick", bus.tick, 0);

    // Simultaneous start and stop in IDLE: stop wins.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
    step();
    checkOutput("t4 start+stop state", bus.state, 0);
    checkOutput("t4 start+stop busy", bus.busy, 0);

    // cfg_div of 0 clamps to 1: tick on every clock.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    step();
    checkOutput("t4 run", bus.state, 1);
    checkOutput("t4 tick e0", bus.tick, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    for (int n = 1; n <= 3; n++) begin
      step();
      checkOutput($sformatf("t4 tick e%0d", n), bus.tick, 1);
      checkOutput($sformatf("t4 clk_out e%0d", n), bus.clk_out, n % 2);
    end

    // Reset mid-RUN with a reload pending.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd5);
    step();
    checkOutput("t5 ready pending", bus.cfg_ready, 0);
    checkOutput("t5 tick before", bus.tick, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    #2 reset = 1'b1;
    #1;
    checkOutput("t5 rst state", bus.state, 0);
    checkOutput("t5 rst tick", bus.tick, 0);
    checkOutput("t5 rst clk_out", bus.clk_out, 0);
    checkOutput("t5 rst cfg_ready", bus.cfg_ready, 1);
    checkOutput("t5 rst busy", bus.busy, 0);
    step();
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    for (int n = 1; n <= 8; n++) begin
      step();
      checkOutput($sformatf("t5 default tick n=%0d", n), bus.tick, (n % 4) == 0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    step();
    checkOutput("t5 back idle", bus.state, 0);

`ifdef DIVCTRL_BURST_EN
    // Burst of 3 ticks at ratio 2: clk_out ends low, one done pulse, IDLE.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd2);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    bus.burst_len = 8'd3;
    step();
    checkOutput("t6 run", bus.state, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    bus.burst_len = 8'd0;
    tickCount = 0;
    for (int n = 1; n <= 10; n++) begin
      step();
      tickCount += int'(bus.tick);
      checkOutput($sformatf("t6 done n=%0d", n), bus.done, n == 7);
      if (n == 6) begin
        checkOutput("t6 stopping", bus.state, 2);
        checkOutput("t6 clk_out last", bus.clk_out, 0);
      end
    end
    checkOutput("t6 tick count", tickCount, 3);
    checkOutput("t6 clk_out", bus.clk_out, 0);
    checkOutput("t6 idle", bus.state, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
